ln_arb: RTL and testbench

- Round-robin arbiter that lets NUM_SRC link sources share one outgoing link (addr/dat/req/ack) into an ln_tgt sink port.
- Both sides use a 4-phase (return-to-zero) req/ack handshake.
- The block latches the winner's addr/dat and drives the downstream handshake.
- It acks the winner only after the downstream acks, then releases.
- Sits between several producer cells and a single ln_tgt i_addr/i_dat/i_req/o_ack port.

---
 rtl/ln_arb_pkg.sv | 37 +++
 rtl/hglobal.v | 24 ++
 rtl/ln_rr_pick.sv | 48 ++++
 rtl/ln_arb.sv | 174 +++++++++++++++++
 tb/tb_ln_arb.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ln_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ln_arb_pkg                                                               |
// | Types and constants shared by ln_arb and its round-robin picker.         |
// | No ports (package).                                                      |
// | Optional feature macro used by ln_arb: LN_ARB_SYNC_EN.                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+

// Same guarded definitions as hglobal.v, so the package compiles whether or
// not that header was read earlier in the compilation unit.
`ifndef HGLOBAL_V
`define HGLOBAL_V
`define ADDRESS_SIZE     8
`define DATA_SIZE        8
`define ON               1'b1
`define OFF              1'b0
`define LN_ARB_IDLE      2'd0
`define LN_ARB_SETUP     2'd1
`define LN_ARB_WAIT_ACK  2'd2
`define LN_ARB_UP_ACK    2'd3
`endif

package ln_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = `LN_ARB_IDLE,
    ST_SETUP    = `LN_ARB_SETUP,
    ST_WAIT_ACK = `LN_ARB_WAIT_ACK,
    ST_UP_ACK   = `LN_ARB_UP_ACK
  } ln_arb_state_e;

  localparam int unsigned LN_ARB_MIN_SRC = 2;
  localparam int unsigned LN_ARB_MAX_SRC = 8;

endpackage
`default_nettype wire

// File: rtl/hglobal.v
`default_nettype none
// +--------------------------------------------------------------------------+
// | hglobal.v                                                                |
// | Global defines shared by the link cells: default link widths, on/off     |
// | literals and the ln_arb state encodings.                                 |
// | No ports (definitions only).                                             |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`ifndef HGLOBAL_V
`define HGLOBAL_V

`define ADDRESS_SIZE     8
`define DATA_SIZE        8

`define ON               1'b1
`define OFF              1'b0

`define LN_ARB_IDLE      2'd0
`define LN_ARB_SETUP     2'd1
`define LN_ARB_WAIT_ACK  2'd2
`define LN_ARB_UP_ACK    2'd3

`endif
`default_nettype wire

// File: rtl/ln_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ln_rr_pick                                                               |
// | Combinational round-robin picker: first set request scanning ptr+1,      |
// | ptr+2, ... modulo NUM_SRC.                                               |
// | Ports: req_i    - request vector                                         |
// |        ptr_i    - index of the last served source                        |
// |        valid_o  - at least one request set                               |
// |        onehot_o - one-hot winner                                         |
// |        index_o  - binary winner index                                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module ln_rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic               valid_o,
  output logic [NUM_SRC-1:0] onehot_o,
  output logic [PW-1:0]      index_o
);

  logic [PW:0] pos;

  // Scan from the farthest candidate (ptr itself) toward the nearest (ptr+1);
  // the last hit written is the highest-priority one, so no "found" flag.
  always_comb begin
    valid_o  = 1'b0;
    onehot_o = '0;
    index_o  = '0;
    pos      = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      pos = {1'b0, ptr_i} + (PW+1)'(i);
      if (pos >= (PW+1)'(NUM_SRC)) begin
        pos = pos - (PW+1)'(NUM_SRC);
      end
      if (req_i[pos[PW-1:0]]) begin
        valid_o                = 1'b1;
        onehot_o               = '0;
        onehot_o[pos[PW-1:0]]  = 1'b1;
        index_o                = pos[PW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ln_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ln_arb                                                                   |
// | Round-robin arbiter merging NUM_SRC 4-phase req/ack links onto one       |
// | downstream link. The winner's addr/dat are latched at grant, o_req is    |
// | raised one cycle later, and the winner is acked only after downstream    |
// | acks; the grant is released once both sides return to zero.             |
// | Optional macro LN_ARB_SYNC_EN: 2-flop synchronizers on i_req and i_ack.  |
// | Ports: i_clk, i_rst_n (async, active low)                                |
// |        i_addr/i_dat/i_req/o_ack - upstream links, source k at slice k    |
// |        o_addr/o_dat/o_req/i_ack - downstream link                        |
// |        o_gnt  - one-hot grant, 0 when idle                               |
// |        o_busy - state not IDLE                                           |
// |        o_err  - sticky protocol-violation flag                           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module ln_arb
  import ln_arb_pkg::*;
#(
  parameter int ASZ     = `ADDRESS_SIZE,
  parameter int DSZ     = `DATA_SIZE,
  parameter int NUM_SRC = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_SRC*ASZ-1:0] i_addr,
  input  logic [NUM_SRC*DSZ-1:0] i_dat,
  input  logic [NUM_SRC-1:0]     i_req,
  output logic [NUM_SRC-1:0]     o_ack,
  output logic [ASZ-1:0]         o_addr,
  output logic [DSZ-1:0]         o_dat,
  output logic                   o_req,
  input  logic                   i_ack,
  output logic [NUM_SRC-1:0]     o_gnt,
  output logic                   o_busy,
  output logic                   o_err
);

  localparam int PW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] req_s;
  logic               ack_s;

`ifdef LN_ARB_SYNC_EN
  logic [NUM_SRC-1:0] req_s1_q, req_s2_q;
  logic               ack_s1_q, ack_s2_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_s1_q <= '0;
      req_s2_q <= '0;
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
    end else begin
      req_s1_q <= i_req;
      req_s2_q <= req_s1_q;
      ack_s1_q <= i_ack;
      ack_s2_q <= ack_s1_q;
    end
  end

  assign req_s = req_s2_q;
  assign ack_s = ack_s2_q;
`else
  assign req_s = i_req;
  assign ack_s = i_ack;
`endif

  ln_arb_state_e      state_q;
  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      idx_q;
  logic [NUM_SRC-1:0] gnt_q;
  logic [NUM_SRC-1:0] ack_q;
  logic               req_q;
  logic               err_q;
  logic [ASZ-1:0]     addr_q;
  logic [DSZ-1:0]     dat_q;

  logic               pick_valid;
  logic [NUM_SRC-1:0] pick_onehot;
  logic [PW-1:0]      pick_idx;
  logic [ASZ-1:0]     sel_addr;
  logic [DSZ-1:0]     sel_dat;
  logic               g_req;

  ln_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .PW      (PW)
  ) u_pick (
    .req_i    (req_s),
    .ptr_i    (ptr_q),
    .valid_o  (pick_valid),
    .onehot_o (pick_onehot),
    .index_o  (pick_idx)
  );

  // One-hot mux of the candidate winner's fields (constant slice indices).
  always_comb begin
    sel_addr = '0;
    sel_dat  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (pick_onehot[k]) begin
        sel_addr = i_addr[k*ASZ +: ASZ];
        sel_dat  = i_dat[k*DSZ +: DSZ];
      end
    end
  end

  // Request level of the currently granted source (0 when nothing granted).
  assign g_req = |(req_s & gnt_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= PW'(NUM_SRC-1);
      idx_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      req_q   <= `OFF;
      err_q   <= `OFF;
      addr_q  <= '0;
      dat_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A still-high downstream ack is stale: hold off until it clears.
          if (!ack_s && pick_valid) begin
            addr_q  <= sel_addr;
            dat_q   <= sel_dat;
            gnt_q   <= pick_onehot;
            idx_q   <= pick_idx;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          req_q <= `ON;
          if (!g_req || ack_s) begin
            err_q <= `ON;
          end
          state_q <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (!g_req) begin
            err_q <= `ON;
          end
          if (ack_s) begin
            req_q   <= `OFF;
            ack_q   <= gnt_q;
            state_q <= ST_UP_ACK;
          end
        end
        ST_UP_ACK: begin
          if (!g_req && !ack_s) begin
            ack_q   <= '0;
            gnt_q   <= '0;
            ptr_q   <= idx_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_ack  = ack_q;
  assign o_addr = addr_q;
  assign o_dat  = dat_q;
  assign o_req  = req_q;
  assign o_gnt  = gnt_q;
  assign o_busy = (state_q != ST_IDLE);
  assign o_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ln_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ln_arb                                                                |
// | Directed self-checking bench for ln_arb (NUM_SRC=4, 8-bit addr/dat).     |
// | Honours LN_ARB_SYNC_EN by adding the synchronizer delay to waits.        |
// | Revision: 1.1 - checks via task, watchdog added                          |
// +--------------------------------------------------------------------------+
module tb_ln_arb;

    localparam int C_N       = 4;
    localparam int C_AW      = 8;
    localparam int C_DW      = 8;
    localparam int C_TIMEOUT = 100000;
`ifdef LN_ARB_SYNC_EN
    localparam int C_LAT = 2;
`else
    localparam int C_LAT = 0;
`endif

    logic              clk     = 1'b0;
    logic              r_rst_n = 1'b0;
    logic [C_N*C_AW-1:0] r_addr = '0;
    logic [C_N*C_DW-1:0] r_dat  = '0;
    logic [C_N-1:0]    r_req   = '0;
    logic              r_ack   = 1'b0;
    logic [C_N-1:0]    w_ack;
    logic [C_AW-1:0]   w_addr;
    logic [C_DW-1:0]   w_dat;
    logic              w_req;
    logic [C_N-1:0]    w_gnt;
    logic              w_busy;
    logic              w_err;

    int n_chk = 0;
    int n_err = 0;
    bit r_done = 1'b0;

    always #5 clk = ~clk;

    ln_arb #(.ASZ(C_AW), .DSZ(C_DW), .NUM_SRC(C_N)) dut (
        .i_clk   (clk),
        .i_rst_n (r_rst_n),
        .i_addr  (r_addr),
        .i_dat   (r_dat),
        .i_req   (r_req),
        .o_ack   (w_ack),
        .o_addr  (w_addr),
        .o_dat   (w_dat),
        .o_req   (w_req),
        .i_ack   (r_ack),
        .o_gnt   (w_gnt),
        .o_busy  (w_busy),
        .o_err   (w_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        r_rst_n = 1'b0;
        r_req   = '0;
        r_ack   = 1'b0;
        step(1);
        r_rst_n = 1'b1;
    endtask

    task automatic xfer(input int src, input bit fresh, input bit reraise,
                        input logic [C_DW-1:0] exp_dat);
        logic [C_N-1:0] oh;
        oh = C_N'(1) << src;
        step(fresh ? 1 + C_LAT : 1);
        check("xfer_gnt", w_gnt, oh);
        check("xfer_dat", w_dat, exp_dat);
        check("xfer_busy", w_busy, 1'b1);
        step(1);
        check("xfer_req", w_req, 1'b1);
        check("xfer_gnt_onehot", $onehot(w_gnt), 1'b1);
        r_ack = 1'b1;
        step(1 + C_LAT);
        check("xfer_ack", w_ack, oh);
        check("xfer_req_low", w_req, 1'b0);
        r_ack      = 1'b0;
        r_req[src] = 1'b0;
        step(1 + C_LAT);
        check("xfer_rel_ack", w_ack, {C_N{1'b0}});
        check("xfer_rel_gnt", w_gnt, {C_N{1'b0}});
        check("xfer_rel_busy", w_busy, 1'b0);
        if (reraise) r_req[src] = 1'b1;
    endtask

    initial begin
        #(C_TIMEOUT);
        if (!r_done) begin
            n_err++;
            $error("FAIL watchdog: wait expired after %0d time units", C_TIMEOUT);
            $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
            $finish;
        end
    end

    initial begin
        step(2);
        check("rst_req", w_req, 1'b0);
        check("rst_ack", w_ack, {C_N{1'b0}});
        check("rst_gnt", w_gnt, {C_N{1'b0}});
        check("rst_busy", w_busy, 1'b0);
        check("rst_err", w_err, 1'b0);
        check("rst_addr", w_addr, 8'h00);
        check("rst_dat", w_dat, 8'h00);
        r_rst_n = 1'b1;
        step(1);

        r_addr[2*C_AW +: C_AW] = 8'h01;
        r_dat[2*C_DW +: C_DW]  = 8'h5A;
        r_req[2]               = 1'b1;
        step(1 + C_LAT);
        check("s1_gnt", w_gnt, 4'b0100);
        check("s1_addr", w_addr, 8'h01);
        check("s1_dat", w_dat, 8'h5A);
        check("s1_req_setup", w_req, 1'b0);
        r_dat[2*C_DW +: C_DW] = 8'hFF;
        step(1);
        check("s1_req_high", w_req, 1'b1);
        step(1);
        check("s1_wait_ack", w_ack, 4'b0000);
        step(1);
        check("s1_wait_req", w_req, 1'b1);
        r_ack = 1'b1;
        step(1 + C_LAT);
        check("s1_ack", w_ack, 4'b0100);
        check("s1_req_low", w_req, 1'b0);
        check("s1_dat_frozen", w_dat, 8'h5A);
        r_ack    = 1'b0;
        r_req[2] = 1'b0;
        step(1 + C_LAT);
        check("s1_rel_ack", w_ack, 4'b0000);
        check("s1_idle", w_busy, 1'b0);
        check("s1_err", w_err, 1'b0);

        r_dat = 32'hA3A2A1A0;
        r_req = 4'b0110;
        xfer(1, 1'b1, 1'b0, 8'hA1);
        xfer(2, 1'b0, 1'b0, 8'hA2);

        do_reset();
        r_req = 4'b1111;
        xfer(0, 1'b1, 1'b1, 8'hA0);
        xfer(1, 1'b0, 1'b1, 8'hA1);
        xfer(2, 1'b0, 1'b1, 8'hA2);
        xfer(3, 1'b0, 1'b1, 8'hA3);
        xfer(0, 1'b0, 1'b0, 8'hA0);
        check("cont_err", w_err, 1'b0);

        do_reset();
        r_req = 4'b1001;
        xfer(0, 1'b1, 1'b1, 8'hA0);
        xfer(3, 1'b0, 1'b0, 8'hA3);
        xfer(0, 1'b0, 1'b0, 8'hA0);

        do_reset();
        r_dat[1*C_DW +: C_DW] = 8'h77;
        r_req = 4'b0010;
        step(1 + C_LAT);
        check("vio_gnt", w_gnt, 4'b0010);
        r_dat[1*C_DW +: C_DW] = 8'h00;
        step(1);
        check("vio_req", w_req, 1'b1);
        r_req = 4'b0000;
        step(1 + C_LAT);
        check("vio_err_set", w_err, 1'b1);
        check("vio_req_held", w_req, 1'b1);
        r_ack = 1'b1;
        step(1 + C_LAT);
        check("vio_ack", w_ack, 4'b0010);
        check("vio_dat", w_dat, 8'h77);
        r_ack = 1'b0;
        step(1 + C_LAT);
        check("vio_idle", w_busy, 1'b0);
        step(3);
        check("vio_err_sticky", w_err, 1'b1);
        do_reset();
        check("vio_err_clr", w_err, 1'b0);

        r_req = 4'b1000;
        r_ack = 1'b1;
        step(1 + C_LAT);
        check("stale_gnt", w_gnt, 4'b0000);
        check("stale_busy", w_busy, 1'b0);
        r_ack = 1'b0;
        step(1 + C_LAT);
        check("stale_then_gnt", w_gnt, 4'b1000);
`ifndef LN_ARB_SYNC_EN
        r_ack = 1'b1;
        step(1);
        check("setup_ack_err", w_err, 1'b1);
        check("setup_ack_req", w_req, 1'b1);
        step(1);
        check("setup_ack_uack", w_ack, 4'b1000);
`endif
        do_reset();

        r_req = 4'b0100;
        step(1 + C_LAT);
        check("mid_gnt", w_gnt, 4'b0100);
        step(1);
        check("mid_req", w_req, 1'b1);
        #2;
        r_rst_n = 1'b0;
        #1;
        check("mid_rst_req", w_req, 1'b0);
        check("mid_rst_ack", w_ack, 4'b0000);
        check("mid_rst_gnt", w_gnt, 4'b0000);
        check("mid_rst_busy", w_busy, 1'b0);
        r_req = 4'b0101;
        #1;
        r_rst_n = 1'b1;
        step(1 + C_LAT);
        check("mid_after_gnt", w_gnt, 4'b0001);

        r_done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
